// File: rtl/uart_pkg.sv
// Shared UART definitions used by the scan-capable receive and transmit blocks.
package uart_pkg;

  localparam int unsigned ClksPerBitDefault = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the serial line; flops reset to the idle (high) level
// and double as the head of the scan chain.
module uart_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  input  logic scan_en_i,
  input  logic scan_i,
  output logic q_o,
  output logic scan_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = scan_en_i ? scan_i : d_i;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q_o    = sync2_q;
  assign scan_o = sync2_q;

endmodule

// File: rtl/uart_rx_scan.sv
// 8N1 UART receiver with a full mux-D scan chain through every flop, synchronizer included.
module uart_rx_scan
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       scan_enable,
  input  logic       scan_in,
  output logic       scan_out,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  logic sync2;

  uart_state_e     state_q, state_d;
  logic [1:0]      state_sh;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;

  uart_sync2 u_sync (
    .clk_i    (clk),
    .rst_ni   (reset),
    .d_i      (rx_in),
    .scan_en_i(scan_enable),
    .scan_i   (scan_in),
    .q_o      (sync2),
    .scan_o   ()
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    state_sh    = '0;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = frame_err_q;

    unique case (state_q)
      StIdle: begin
        if (!sync2) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          // Line back high at mid start bit: treat as a glitch.
          if (!sync2) begin
            state_d   = StData;
            bit_idx_d = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          shift_d = {sync2, shift_q[7:1]};
          cnt_d   = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == CntLast) begin
          rx_data_d   = shift_q;
          rx_valid_d  = 1'b1;
          frame_err_d = ~sync2;
          cnt_d       = '0;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    endcase

    // Scan shift: chain continues from sync2 through the FSM flops to frame_err.
    if (scan_enable) begin
      {state_sh, cnt_d, bit_idx_d, shift_d, rx_data_d, rx_valid_d, frame_err_d} =
        {sync2, state_q, cnt_q, bit_idx_q, shift_q, rx_data_q, rx_valid_q};
      state_d = uart_state_e'(state_sh);
    end
  end

  always_comb begin
    rx_busy   = (state_q != StIdle);
    scan_out  = frame_err_q;
    rx_data   = rx_data_q;
    rx_valid  = rx_valid_q;
    frame_err = frame_err_q;
  end

endmodule

// File: tb/tb_uart_rx_scan.sv
// Directed bench for uart_rx_scan: frames, framing error, glitch, mid-frame reset, scan chain.
module tb_uart_rx_scan;

  localparam int unsigned Cpb = 8;

  logic       clk;
  logic       reset;
  logic       rx_in;
  logic       scan_enable;
  logic       scan_in;
  logic       scan_out;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  int n_checks;
  int n_errors;
  int cyc;

  logic [7:0] pd_q[$];
  logic       pf_q[$];
  int         pc_q[$];

  uart_rx_scan #(.CLKS_PER_BIT(Cpb)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_in      (rx_in),
    .scan_enable(scan_enable),
    .scan_in    (scan_in),
    .scan_out   (scan_out),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      pd_q.push_back(rx_data);
      pf_q.push_back(frame_err);
      pc_q.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_pulses();
    pd_q.delete();
    pf_q.delete();
    pc_q.delete();
  endtask

  task automatic check_pulse(input string tag, input int idx, input logic [7:0] d,
                             input logic fe);
    if (idx < pd_q.size()) begin
      check_eq({tag, "_data"}, pd_q[idx], d);
      check_eq({tag, "_ferr"}, pf_q[idx], fe);
    end else begin
      check_eq({tag, "_missing"}, pd_q.size(), idx + 1);
    end
  endtask

  // Called and returns at 1 time unit after a rising edge.
  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (Cpb) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit, output int t0);
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    drive_bit(stop_bit);
  endtask

  // Bit j of vin goes in on shift j; vout[j] is scan_out seen before shift j.
  task automatic scan_shift(input logic [27:0] vin, output logic [27:0] vout);
    for (int j = 0; j < 28; j++) begin
      scan_in = vin[j];
      vout[j] = scan_out;
      @(posedge clk);
      #1;
    end
  endtask

  int          t0;
  logic [27:0] sv;

  initial begin
    reset       = 1'b0;
    rx_in       = 1'b1;
    scan_enable = 1'b0;
    scan_in     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", rx_busy, 0);
    check_eq("rst_scan_out", scan_out, 0);
    check_eq("rst_data", rx_data, 0);
    check_eq("rst_valid", rx_valid, 0);
    check_eq("rst_ferr", frame_err, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single good frame with latency check
    clear_pulses();
    send_frame(8'h55, 1'b1, t0);
    drive_bit(1'b1);
    check_eq("f55_n", pd_q.size(), 1);
    check_pulse("f55", 0, 8'h55, 1'b0);
    if (pc_q.size() > 0) check_eq("f55_latency", pc_q[0], t0 + 79);
    check_eq("f55_busy", rx_busy, 0);

    // Back-to-back frames, one idle bit between
    clear_pulses();
    send_frame(8'hA5, 1'b1, t0);
    drive_bit(1'b1);
    send_frame(8'h3C, 1'b1, t0);
    drive_bit(1'b1);
    check_eq("b2b_n", pd_q.size(), 2);
    check_pulse("b2b0", 0, 8'hA5, 1'b0);
    check_pulse("b2b1", 1, 8'h3C, 1'b0);

    // Framing error then recovery
    clear_pulses();
    send_frame(8'hFF, 1'b0, t0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check_eq("ferr_hold", frame_err, 1);
    check_eq("ferr_data", rx_data, 8'hFF);
    send_frame(8'h00, 1'b1, t0);
    drive_bit(1'b1);
    check_eq("ferr_n", pd_q.size(), 2);
    check_pulse("ferr0", 0, 8'hFF, 1'b1);
    check_pulse("ferr1", 1, 8'h00, 1'b0);
    check_eq("ferr_clear", frame_err, 0);

    // Reset in the middle of the data bits
    send_frame(8'hC3, 1'b0, t0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check_eq("abort_pre_ferr", frame_err, 1);
    check_eq("abort_pre_data", rx_data, 8'hC3);
    clear_pulses();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    check_eq("abort_pre_busy", rx_busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("abort_busy", rx_busy, 0);
    check_eq("abort_data", rx_data, 0);
    check_eq("abort_ferr", frame_err, 0);
    check_eq("abort_valid", rx_valid, 0);
    check_eq("abort_scan_out", scan_out, 0);
    rx_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2 * Cpb) @(posedge clk);
    #1;
    send_frame(8'h81, 1'b1, t0);
    drive_bit(1'b1);
    check_eq("abort_n", pd_q.size(), 1);
    check_pulse("abort_next", 0, 8'h81, 1'b0);

    // Short low glitch on an idle line
    clear_pulses();
    rx_in = 1'b0;
    repeat (Cpb / 2 - 1) @(posedge clk);
    #1;
    rx_in = 1'b1;
    check_eq("glitch_busy_mid", rx_busy, 1);
    repeat (20) @(posedge clk);
    #1;
    check_eq("glitch_busy_end", rx_busy, 0);
    check_eq("glitch_n", pd_q.size(), 0);

    // Scan chain: shift pattern through, then capture one functional cycle
    scan_enable = 1'b1;
    scan_shift(28'h5555555, sv);
    scan_shift(28'h5555555, sv);
    check_eq("scan_pass", sv, 28'h5555555);
    scan_enable = 1'b0;
    @(posedge clk);
    #1;
    scan_enable = 1'b1;
    // Loads STOP with cnt at its last value, shift_reg 0x5A, frame_err 1
    scan_shift(28'hFE16801, sv);
    check_eq("scan_capture", sv, 28'h9755555);
    scan_enable = 1'b0;
    @(posedge clk);
    #1;
    check_eq("resume_valid", rx_valid, 1);
    check_eq("resume_data", rx_data, 8'h5A);
    check_eq("resume_ferr", frame_err, 0);
    check_eq("resume_busy", rx_busy, 0);
    @(posedge clk);
    #1;
    check_eq("resume_valid_drop", rx_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_scan.md
UART_RX_SCAN -- requirements
Module: uart_rx_scan

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 8, clocks per serial bit; even, >=4.
REQ-002 SHALL have port: clk  input  1  single clock, all flops on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: rx_in  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port: scan_enable  input  1  1 = scan shift mode, 0 = functional.
REQ-006 SHALL have port: scan_in  input  1  scan chain serial input.
REQ-007 SHALL have port: scan_out  output  1  scan chain serial output.
REQ-008 SHALL have port: rx_data  output  8  last received byte.
REQ-009 SHALL have port: rx_valid  output  1  one-cycle pulse, byte complete.
REQ-010 SHALL have port: frame_err  output  1  stop bit sampled low on last frame.
REQ-011 SHALL have port: rx_busy  output  1  high whenever state != IDLE.

Function
REQ-012 SHALL pass rx_in through a 2-flop synchronizer (sync1, sync2); the FSM uses sync2 only.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP with baud counter cnt and bit index bit_idx (3 bits).
REQ-014 IDLE: on sync2==0, SHALL go to START with cnt=0.
REQ-015 START: at cnt==CLKS_PER_BIT/2-1, SHALL go to DATA (cnt=0, bit_idx=0) if sync2==0, else return to IDLE (glitch reject); otherwise cnt+1.
REQ-016 DATA: at cnt==CLKS_PER_BIT-1, SHALL shift sync2 in LSB-first (shift_reg <= {sync2, shift_reg[7:1]}), clear cnt; go to STOP if bit_idx==7, else bit_idx+1.
REQ-017 STOP: at cnt==CLKS_PER_BIT-1, SHALL load rx_data<=shift_reg, pulse rx_valid for exactly one cycle, load frame_err<=~sync2, and go to IDLE.
REQ-018 On framing error, rx_data SHALL still update; frame_err holds until the next STOP completes.
REQ-019 Latency: if edge k is the first edge sampling rx_in low, rx_valid SHALL be high in the cycle after edge k+2+CLKS_PER_BIT/2+9*CLKS_PER_BIT (k+78 for default).
REQ-020 A falling edge on sync2 during STOP SHALL NOT be taken; the next start bit is detected only from IDLE.
REQ-021 With scan_enable=1, all flops SHALL shift as one chain, ignoring functional next-state; rx_valid SHALL NOT pulse from function.
REQ-022 Chain order SHALL be scan_in -> sync1 -> sync2 -> state[1:0] -> cnt (MSB first) -> bit_idx[2:0] -> shift_reg[7:0] -> rx_data[7:0] -> rx_valid -> frame_err -> scan_out.
REQ-023 Chain length SHALL be 28 for default parameter; cnt width is clog2(CLKS_PER_BIT).
REQ-024 On scan_enable 1->0, the FSM SHALL resume from the shifted-in register contents.

Reset
REQ-025 reset low SHALL immediately force sync1=sync2=1, state=IDLE, and cnt, bit_idx, shift_reg, rx_data, rx_valid, frame_err to 0, so rx_busy=0 and scan_out=0.
REQ-026 Reset SHALL override scan_enable and a frame in progress; an aborted frame SHALL produce no rx_valid.
REQ-027 After reset release, the first frame SHALL be received only after rx_in has been sampled high and then low.

Structure
REQ-028 State encoding (IDLE=0, START=1, DATA=2, STOP=3) and the default CLKS_PER_BIT SHALL reside in shared package uart_pkg, also used by uart_tx_scan.
REQ-029 The synchronizer SHALL be sub-module uart_sync2 with reset-to-1 flops and a scan input/output pair; all other logic stays flat.

Verification
REQ-030 Frame 0x55 with good stop -> rx_data=8'h55, rx_valid one cycle at edge k+78, frame_err=0.
REQ-031 Back-to-back frames 0xA5, 0x3C with one idle bit between -> two rx_valid pulses, rx_data 8'hA5 then 8'h3C.
REQ-032 Frame 0xFF with stop bit low -> rx_data=8'hFF, frame_err=1; next good frame 0x00 -> frame_err=0.
REQ-033 Low glitch of CLKS_PER_BIT/2-1 cycles on idle line -> no rx_valid, rx_busy returns 0, state IDLE.
REQ-034 Reset low mid-DATA after 4 bits -> all outputs 0 immediately, no rx_valid; next full frame 0x81 received correctly.
REQ-035 scan_enable=1, shift 28-bit pattern 1010... -> same pattern on scan_out after 28 cycles; capture with scan_enable=0 for one cycle, shift out, compare against the expected next state.
